pwm_multi_ctr: RTL and testbench



---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_channel.sv | 150 +++++++++++++++
 rtl/pwm_multi_ctr.sv | 57 +++++
 tb/tb_pwm_multi_ctr.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and helpers for the multi-channel PWM counter.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        PWM_OFF     = 2'd0,
        PWM_ONESHOT = 2'd1,
        PWM_CONT    = 2'd2,
        PWM_RSVD    = 2'd3
    } pwm_mode_t;

    localparam int c_MIN_IDX_W = 1;

    // Channel-select width; a single channel still gets a 1-bit index port.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : c_MIN_IDX_W;
    endfunction

    // The reserved encoding behaves exactly like OFF.
    function automatic pwm_mode_t sanitize_mode(input logic [1:0] m);
        return (m == PWM_RSVD) ? PWM_OFF : pwm_mode_t'(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One pulse channel: one-shot or continuous PWM, double-buffered duty.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_wr,
    input  logic [1:0]       i_wr_mode,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_pw,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] c_ZERO     = '0;

    pwm_mode_t        r_mode_q,   w_mode_d;
    pwm_mode_t        r_shadow_q, w_shadow_d;
    logic [WIDTH-1:0] r_cnt_q,    w_cnt_d;
    logic [WIDTH-1:0] r_buf_q,    w_buf_d;
    logic [WIDTH-1:0] r_act_q,    w_act_d;
    logic             r_pend_q,   w_pend_d;
    logic             r_pw_q,     w_pw_d;
    logic             r_busy_q,   w_busy_d;
    logic             r_done_q,   w_done_d;

    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_wrap;
    logic             w_restart;

    assign w_cnt_inc = r_cnt_q + WIDTH'(1);
    assign w_wrap    = (r_cnt_q == c_ALL_ONES);
    // CONT->CONT is the only pending update that waits for the period wrap.
    assign w_restart = r_pend_q &&
                       ((r_shadow_q != r_mode_q) || (r_shadow_q == PWM_ONESHOT));

    always_comb begin
        w_mode_d   = r_mode_q;
        w_shadow_d = r_shadow_q;
        w_cnt_d    = r_cnt_q;
        w_buf_d    = r_buf_q;
        w_act_d    = r_act_q;
        w_pend_d   = r_pend_q;
        w_pw_d     = r_pw_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;

        if (i_tick) begin
            if (w_restart) begin
                w_mode_d = r_shadow_q;
                w_pend_d = 1'b0;
                case (r_shadow_q)
                    PWM_ONESHOT: begin
                        w_cnt_d  = r_buf_q;
                        w_pw_d   = 1'b1;
                        w_busy_d = 1'b1;
                    end
                    PWM_CONT: begin
                        w_cnt_d  = c_ZERO;
                        w_act_d  = r_buf_q;
                        w_pw_d   = (r_buf_q != c_ZERO);
                        w_busy_d = 1'b0;
                    end
                    default: begin
                        w_cnt_d  = c_ZERO;
                        w_pw_d   = 1'b0;
                        w_busy_d = 1'b0;
                    end
                endcase
            end else begin
                case (r_mode_q)
                    PWM_ONESHOT: begin
                        if (r_busy_q) begin
                            if (w_wrap) begin
                                w_pw_d   = 1'b0;
                                w_busy_d = 1'b0;
                                w_done_d = 1'b1;
                            end else begin
                                w_cnt_d = w_cnt_inc;
                            end
                        end
                    end
                    PWM_CONT: begin
                        w_cnt_d = w_cnt_inc;
                        // Deferred duty swap lands exactly on the period boundary.
                        if (w_wrap && r_pend_q) begin
                            w_act_d  = r_buf_q;
                            w_pend_d = 1'b0;
                            w_pw_d   = (r_buf_q != c_ZERO);
                        end else begin
                            w_pw_d = (w_cnt_inc < r_act_q);
                        end
                    end
                    default: begin
                        w_cnt_d  = c_ZERO;
                        w_pw_d   = 1'b0;
                        w_busy_d = 1'b0;
                        w_pend_d = 1'b0;
                    end
                endcase
            end
        end

        // A write in a tick cycle lands after the tick has used the old state.
        if (i_wr) begin
            w_buf_d    = i_wr_data;
            w_shadow_d = sanitize_mode(i_wr_mode);
            w_pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q   <= PWM_OFF;
            r_shadow_q <= PWM_OFF;
            r_cnt_q    <= c_ZERO;
            r_buf_q    <= c_ZERO;
            r_act_q    <= c_ZERO;
            r_pend_q   <= 1'b0;
            r_pw_q     <= 1'b0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_mode_q   <= w_mode_d;
            r_shadow_q <= w_shadow_d;
            r_cnt_q    <= w_cnt_d;
            r_buf_q    <= w_buf_d;
            r_act_q    <= w_act_d;
            r_pend_q   <= w_pend_d;
            r_pw_q     <= w_pw_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign o_pw   = r_pw_q;
    assign o_busy = r_busy_q;
    assign o_done = r_done_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ctr.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ctr
// Brief    : Multi-channel pulse/PWM generator with per-channel write decode.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ctr
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int CHANNELS = 2
) (
    input  logic                          MasterClock,
    input  logic                          RESET,
    input  logic                          XCK_EN,
    input  logic                          WR,
    input  logic [ch_idx_w(CHANNELS)-1:0] WR_CH,
    input  logic [1:0]                    WR_MODE,
    input  logic [WIDTH-1:0]              WR_DATA,
    output logic [CHANNELS-1:0]           PW,
    output logic [CHANNELS-1:0]           BUSY,
    output logic [CHANNELS-1:0]           DONE
);

    localparam int                c_CH_W   = ch_idx_w(CHANNELS);
    localparam logic [c_CH_W:0]   c_NUM_CH = (c_CH_W + 1)'(CHANNELS);

    logic w_wr_valid;

    // Out-of-range channel indices are dropped before reaching any channel.
    assign w_wr_valid = WR && ({1'b0, WR_CH} < c_NUM_CH);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(gi);

            logic w_wr_sel;
            assign w_wr_sel = w_wr_valid && (WR_CH == c_IDX);

            pwm_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk       (MasterClock),
                .rst       (RESET),
                .i_tick    (XCK_EN),
                .i_wr      (w_wr_sel),
                .i_wr_mode (WR_MODE),
                .i_wr_data (WR_DATA),
                .o_pw      (PW[gi]),
                .o_busy    (BUSY[gi]),
                .o_done    (DONE[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ctr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ctr
// Brief    : Self-checking bench: behavioural channel model plus directed pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ctr;

    localparam int W   = 7;
    localparam int CH  = 3;
    localparam int PER = 1 << W;

    logic          clk     = 1'b0;
    logic          RESET   = 1'b1;
    logic          XCK_EN  = 1'b1;
    logic          WR      = 1'b0;
    logic [1:0]    WR_CH   = 2'd0;
    logic [1:0]    WR_MODE = 2'd0;
    logic [W-1:0]  WR_DATA = '0;
    logic [CH-1:0] PW, BUSY, DONE;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pwm_multi_ctr #(.WIDTH(W), .CHANNELS(CH)) dut (
        .MasterClock (clk),
        .RESET       (RESET),
        .XCK_EN      (XCK_EN),
        .WR          (WR),
        .WR_CH       (WR_CH),
        .WR_MODE     (WR_MODE),
        .WR_DATA     (WR_DATA),
        .PW          (PW),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one-shot tracks ticks remaining, CONT tracks phase in period.
    int m_mode[CH], m_shadow[CH], m_pend[CH], m_buf[CH], m_duty[CH], m_phase[CH], m_rem[CH];
    bit m_pw[CH], m_busy[CH], m_done[CH];

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (RESET) begin
                m_mode[c] = 0; m_shadow[c] = 0; m_pend[c] = 0; m_buf[c] = 0;
                m_duty[c] = 0; m_phase[c] = 0; m_rem[c] = 0;
                m_pw[c] = 0; m_busy[c] = 0; m_done[c] = 0;
            end else begin
                m_done[c] = 0;
                if (XCK_EN) begin
                    if (m_pend[c] != 0 && (m_shadow[c] != m_mode[c] || m_shadow[c] == 1)) begin
                        m_mode[c] = m_shadow[c];
                        m_pend[c] = 0;
                        if (m_mode[c] == 1) begin
                            m_rem[c] = PER - m_buf[c]; m_pw[c] = 1; m_busy[c] = 1;
                        end else if (m_mode[c] == 2) begin
                            m_phase[c] = 0; m_duty[c] = m_buf[c];
                            m_pw[c] = (m_duty[c] > 0); m_busy[c] = 0;
                        end else begin
                            m_pw[c] = 0; m_busy[c] = 0;
                        end
                    end else if (m_mode[c] == 1) begin
                        if (m_busy[c]) begin
                            m_rem[c]--;
                            if (m_rem[c] == 0) begin
                                m_pw[c] = 0; m_busy[c] = 0; m_done[c] = 1;
                            end
                        end
                    end else if (m_mode[c] == 2) begin
                        m_phase[c] = (m_phase[c] + 1) % PER;
                        if (m_phase[c] == 0 && m_pend[c] != 0) begin
                            m_duty[c] = m_buf[c]; m_pend[c] = 0;
                        end
                        m_pw[c] = (m_phase[c] < m_duty[c]);
                    end else begin
                        m_pend[c] = 0; m_pw[c] = 0; m_busy[c] = 0;
                    end
                end
                if (WR && int'(WR_CH) == c) begin
                    m_buf[c]    = int'(WR_DATA);
                    m_shadow[c] = (WR_MODE == 2'd3) ? 0 : int'(WR_MODE);
                    m_pend[c]   = 1;
                end
            end
        end
    end

    // Per-cycle compare plus activity counters used by the directed pins.
    logic [CH-1:0] e_pw, e_busy, e_done;
    int  hi_cnt[CH], rise_cnt[CH], done_cnt[CH], busy_cnt[CH];
    bit  prev_pw[CH];
    int  mon_ch  = 0;
    int  run_len = 0;
    int  runs_q[$];

    always @(posedge clk) begin
        #2;
        for (int c = 0; c < CH; c++) begin
            e_pw[c] = m_pw[c]; e_busy[c] = m_busy[c]; e_done[c] = m_done[c];
        end
        check("pw_vs_model",   int'(PW),   int'(e_pw));
        check("busy_vs_model", int'(BUSY), int'(e_busy));
        check("done_vs_model", int'(DONE), int'(e_done));
        for (int c = 0; c < CH; c++) begin
            if (PW[c]) hi_cnt[c]++;
            if (PW[c] && !prev_pw[c]) rise_cnt[c]++;
            prev_pw[c] = PW[c];
            if (DONE[c]) done_cnt[c]++;
            if (BUSY[c]) busy_cnt[c]++;
        end
        if (PW[mon_ch]) run_len++;
        else if (run_len > 0) begin
            runs_q.push_back(run_len);
            run_len = 0;
        end
    end

    // Tick generator: tick_div=N ticks every Nth cycle, 0 gives random ticks.
    int tick_div = 1;
    int cyc      = 0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tick_div == 0) XCK_EN = 1'($urandom_range(0, 1));
            else               XCK_EN = ((cyc % tick_div) == 0);
        end
    end

    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input int ch, input int mode, input int data);
        @(negedge clk);
        WR = 1'b1; WR_CH = ch[1:0]; WR_MODE = mode[1:0]; WR_DATA = data[W-1:0];
        @(negedge clk);
        WR = 1'b0;
    endtask

    task automatic clr_counts();
        for (int c = 0; c < CH; c++) begin
            hi_cnt[c] = 0; rise_cnt[c] = 0; done_cnt[c] = 0; busy_cnt[c] = 0;
        end
    endtask

    function automatic int rand_data();
        int sel = $urandom_range(0, 5);
        if (sel == 0) return 0;
        if (sel == 1) return PER - 1;
        return $urandom_range(0, PER - 1);
    endfunction

    int ok;
    int seen_low;

    initial begin
        clr_counts();
        repeat (3) @(negedge clk);
        check("reset_pw",   int'(PW),   0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        RESET = 1'b0;

        // One-shot lengths with a tick every cycle.
        tick_div = 1;
        wait_cyc(2);
        clr_counts(); do_write(0, 1, 120); wait_cyc(20);
        check("os120_high", hi_cnt[0], 8);
        check("os120_done", done_cnt[0], 1);
        check("os120_busy", busy_cnt[0], 8);
        clr_counts(); do_write(0, 1, 127); wait_cyc(10);
        check("os127_high", hi_cnt[0], 1);
        check("os127_done", done_cnt[0], 1);
        clr_counts(); do_write(0, 1, 0); wait_cyc(140);
        check("os0_high", hi_cnt[0], 128);
        check("os0_done", done_cnt[0], 1);
        check("os0_busy", busy_cnt[0], 128);

        // Continuous on ch1, tick every 4th cycle: 512-cycle period, 128 cycles high.
        tick_div = 4;
        mon_ch = 1; run_len = 0;
        do_write(1, 2, 32); wait_cyc(600);
        clr_counts(); wait_cyc(512);
        check("cont32_high", hi_cnt[1], 128);
        check("cont32_rises", rise_cnt[1], 1);

        // Duty change mid high phase: this period stays 32 ticks, next is 96.
        ok = 0; seen_low = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (PW[1] == 1'b0) seen_low = 1;
            else if (seen_low != 0) begin ok = 1; break; end
        end
        check("cont_rise_seen", ok, 1);
        runs_q.delete();
        wait_cyc(40);
        do_write(1, 2, 96);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (runs_q.size() >= 2) begin ok = 1; break; end
        end
        check("glitch_runs_seen", ok, 1);
        if (runs_q.size() >= 2) begin
            check("glitch_run_old", runs_q[0], 128);
            check("glitch_run_new", runs_q[1], 384);
        end

        do_write(1, 2, 0); wait_cyc(700);
        clr_counts(); wait_cyc(1536);
        check("cont0_high", hi_cnt[1], 0);

        // Retrigger at cnt=125 on a tick cycle.
        tick_div = 1;
        wait_cyc(3);
        mon_ch = 0; run_len = 0; runs_q.delete();
        clr_counts();
        do_write(0, 1, 120);
        repeat (5) @(negedge clk);
        do_write(0, 1, 100);
        wait_cyc(60);
        check("retrig_high", hi_cnt[0], 35);
        check("retrig_done", done_cnt[0], 1);
        check("retrig_runs", runs_q.size(), 1);
        if (runs_q.size() >= 1) check("retrig_run_len", runs_q[0], 35);

        // Out-of-range channel index must not touch any channel.
        clr_counts();
        do_write(3, 1, 5); wait_cyc(50);
        check("badidx_high", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
        check("badidx_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);

        // ch0 CONT and ch2 ONESHOT side by side; ch1 turned OFF.
        do_write(1, 0, 0); wait_cyc(2);
        clr_counts();
        for (int i = 0; i < 20; i++) begin
            tick_div = $urandom_range(0, 4);
            if (i % 2 == 0) do_write(0, 2, rand_data());
            else            do_write(2, 1, rand_data());
            wait_cyc($urandom_range(50, 300));
        end
        check("iso_ch1_high", hi_cnt[1], 0);
        check("iso_ch1_busy", busy_cnt[1], 0);

        // Fully random writes, modes, channels and tick patterns.
        for (int i = 0; i < 60; i++) begin
            tick_div = $urandom_range(0, 3);
            do_write($urandom_range(0, 3), $urandom_range(0, 3), rand_data());
            wait_cyc($urandom_range(0, 150));
        end

        // Reset with activity in flight and ticks running.
        tick_div = 1;
        do_write(0, 2, 64); do_write(2, 1, 0); wait_cyc(10);
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_pw",   int'(PW),   0);
        check("rst2_busy", int'(BUSY), 0);
        check("rst2_done", int'(DONE), 0);
        RESET = 1'b0;
        clr_counts(); wait_cyc(10);
        check("rst2_after_high", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
        check("rst2_after_done", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
